// File: rtl/multicycle_adder.sv
// multicycle_adder
//   Multi-cycle add/subtract unit. A WIDTH-bit operand pair is processed
//   CHUNK bits per clock through a CHUNK-long ripple chain of full adders.
//   The carry is registered between chunks, so the critical path does not
//   depend on WIDTH. In subtract mode, b is inverted and the borrow-in is
//   folded into the carry-in.
//
// Ports
//   clk, rst         rising-edge clock; synchronous active-high reset
//   in_valid/in_ready  operand handshake (a, b, cin, sub)
//   a, b             WIDTH-bit operands
//   cin              carry-in (add) / borrow-in (subtract)
//   sub              0: a+b+cin   1: a-b-cin
//   out_valid/out_ready result handshake (sum, cout, ovf)
//   sum              WIDTH-bit result, modulo 2^WIDTH
//   cout             raw carry out of the MSB (subtract: 1 = no borrow)
//   ovf              two's-complement signed overflow
module multicycle_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("multicycle_adder: need 1 <= CHUNK <= WIDTH and WIDTH %% CHUNK == 0");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             c_out;

  always_comb begin
    logic c;

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    // Chunk mux built from constant part-selects compared against idx,
    // which keeps every select statically sized.
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      if (idx_q == IDXW'(k)) begin
        a_chunk = a_q[k*CHUNK +: CHUNK];
        b_chunk = b_q[k*CHUNK +: CHUNK];
      end
    end

    // CHUNK-long ripple chain of full-adder cells.
    c       = carry_q;
    s_chunk = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ c;
      c          = (a_chunk[i] & b_chunk[i]) | (c & (a_chunk[i] ^ b_chunk[i]));
    end
    c_out = c;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = cin ^ sub;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        for (int unsigned k = 0; k < NCHUNK; k++) begin
          if (idx_q == IDXW'(k)) begin
            sum_d[k*CHUNK +: CHUNK] = s_chunk;
          end
        end
        carry_d = c_out;
        if (idx_q == IDXW'(NCHUNK - 1)) begin
          cout_d  = c_out;
          // s_chunk[CHUNK-1] is the final sum MSB on the last chunk.
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_chunk[CHUNK-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE) && !rst;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder
//   Directed table plus hand-written handshake/reset sequences on an
//   8/2 instance, and randomised sweeps on 8/8, 8/1 and 32/4 instances.
//   All instances share one stimulus bus; sel picks the active one.
module tb_multicycle_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        cin;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  int          sel;

  logic        ir0, ir1, ir2, ir3;
  logic        ov0, ov1, ov2, ov3;
  logic        co0, co1, co2, co3;
  logic        of0, of1, of2, of3;
  logic [7:0]  sum0, sum1, sum2;
  logic [31:0] sum3;

  logic        m_ir, m_ov, m_co, m_of;
  logic [31:0] m_sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_adder #(.WIDTH(8), .CHUNK(2)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 0), .in_ready(ir0),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
    .out_valid(ov0), .out_ready(out_ready && sel == 0),
    .sum(sum0), .cout(co0), .ovf(of0)
  );

  multicycle_adder #(.WIDTH(8), .CHUNK(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 1), .in_ready(ir1),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
    .out_valid(ov1), .out_ready(out_ready && sel == 1),
    .sum(sum1), .cout(co1), .ovf(of1)
  );

  multicycle_adder #(.WIDTH(8), .CHUNK(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2), .in_ready(ir2),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
    .out_valid(ov2), .out_ready(out_ready && sel == 2),
    .sum(sum2), .cout(co2), .ovf(of2)
  );

  multicycle_adder #(.WIDTH(32), .CHUNK(4)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 3), .in_ready(ir3),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov3), .out_ready(out_ready && sel == 3),
    .sum(sum3), .cout(co3), .ovf(of3)
  );

  always_comb begin
    m_ir  = ir0;
    m_ov  = ov0;
    m_co  = co0;
    m_of  = of0;
    m_sum = 32'(sum0);
    case (sel)
      1: begin m_ir = ir1; m_ov = ov1; m_co = co1; m_of = of1; m_sum = 32'(sum1); end
      2: begin m_ir = ir2; m_ov = ov2; m_co = co2; m_of = of2; m_sum = 32'(sum2); end
      3: begin m_ir = ir3; m_ov = ov3; m_co = co3; m_of = of3; m_sum = sum3;      end
      default: ;
    endcase
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        o;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete transaction on the selected instance. lat counts cycles
  // from the accept cycle (cycle 0) to the first cycle with out_valid=1.
  task automatic run_op(input logic [31:0] ai, input logic [31:0] bi,
                        input logic ci, input logic si, input int stall,
                        output logic [31:0] s, output logic c, output logic o,
                        output int lat);
    int n;
    n = 0;
    while (!m_ir && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_op", m_ir, 1);
    a = ai; b = bi; cin = ci; sub = si; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!m_ov && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    repeat (stall) @(negedge clk);
    s = m_sum;
    c = m_co;
    o = m_of;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[8];
    logic [31:0] s;
    logic        c, o;
    int          lat;

    tbl[0] = '{32'h5A, 32'h3C, 1'b0, 1'b0, 32'h96, 1'b0, 1'b1};
    tbl[1] = '{32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0};
    tbl[2] = '{32'h10, 32'h20, 1'b0, 1'b1, 32'hF0, 1'b0, 1'b0};
    tbl[3] = '{32'h05, 32'h02, 1'b1, 1'b1, 32'h02, 1'b1, 1'b0};
    tbl[4] = '{32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1};
    tbl[5] = '{32'h0F, 32'hF0, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0};
    tbl[6] = '{32'h00, 32'h00, 1'b0, 1'b1, 32'h00, 1'b1, 1'b0};
    tbl[7] = '{32'h80, 32'h01, 1'b0, 1'b1, 32'h7F, 1'b1, 1'b1};

    sel = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", m_ir, 0);
    check("rst_out_valid", m_ov, 0);
    check("rst_sum", m_sum, 0);
    check("rst_cout", m_co, 0);
    check("rst_ovf", m_of, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", m_ir, 1);
    @(negedge clk);

    // Directed table, 8/2: result latency is NCHUNK+1 = 5
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, i % 3, s, c, o, lat);
      check($sformatf("tbl%0d_sum", i), s, tbl[i].s);
      check($sformatf("tbl%0d_cout", i), c, tbl[i].c);
      check($sformatf("tbl%0d_ovf", i), o, tbl[i].o);
      check($sformatf("tbl%0d_lat", i), lat, 5);
      check($sformatf("tbl%0d_ov_drop", i), m_ov, 0);
    end

    // Backpressure in DONE with in_valid held high throughout
    a = 32'h5A; b = 32'h3C; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!m_ov && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bp_lat", lat, 5);
    a = 32'h11; b = 32'h22; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp%0d_out_valid", i), m_ov, 1);
      check($sformatf("bp%0d_in_ready", i), m_ir, 0);
      check($sformatf("bp%0d_sum", i), m_sum, 32'h96);
      check($sformatf("bp%0d_cout", i), m_co, 0);
      check($sformatf("bp%0d_ovf", i), m_of, 1);
      if (i < 3) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_out_valid", m_ov, 0);
    check("bp_release_in_ready", m_ir, 1);
    // in_valid still high: accepted on this IDLE cycle
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_accept_in_ready", m_ir, 0);
    lat = 1;
    while (!m_ov && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bp_next_lat", lat, 5);
    check("bp_next_sum", m_sum, 32'h33);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during CALC (previous result left cout=1, ovf=1)
    run_op(32'h80, 32'h01, 1'b0, 1'b1, 0, s, c, o, lat);
    check("pre_rst_cout", c, 1);
    check("pre_rst_ovf", o, 1);
    a = 32'hF0; b = 32'h0F; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready_comb", m_ir, 0);
    @(negedge clk);
    check("midrst_out_valid", m_ov, 0);
    check("midrst_sum", m_sum, 0);
    check("midrst_cout", m_co, 0);
    check("midrst_ovf", m_of, 0);
    check("midrst_in_ready", m_ir, 0);
    rst = 1'b0;
    #1;
    check("after_rst_in_ready", m_ir, 1);
    run_op(32'h01, 32'h01, 1'b0, 1'b0, 1, s, c, o, lat);
    check("after_rst_sum", s, 32'h02);
    check("after_rst_cout", c, 0);
    check("after_rst_ovf", o, 0);
    check("after_rst_lat", lat, 5);

    // Randomised sweeps against a signed/unsigned arithmetic model
    for (int g = 1; g <= 3; g++) begin
      int          w, nc;
      logic [31:0] mask;
      sel = g;
      w   = (g == 3) ? 32 : 8;
      nc  = (g == 1) ? 1 : ((g == 2) ? 8 : 8);
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      @(negedge clk);
      for (int n = 0; n < 1000; n++) begin
        logic [31:0] ai, bi, exp_s;
        logic        ci, si, exp_c, exp_o;
        longint      ua, ub, sa, sb, sres, maxv, minv;
        ai = $urandom() & mask;
        bi = $urandom() & mask;
        ci = 1'($urandom_range(0, 1));
        si = 1'($urandom_range(0, 1));
        ua = longint'(ai);
        ub = longint'(bi);
        sa = ai[w-1] ? ua - (longint'(1) << w) : ua;
        sb = bi[w-1] ? ub - (longint'(1) << w) : ub;
        sres = si ? (sa - sb - longint'(ci)) : (sa + sb + longint'(ci));
        maxv = (longint'(1) << (w - 1)) - 1;
        minv = -(longint'(1) << (w - 1));
        exp_o = (sres > maxv) || (sres < minv);
        exp_s = 32'(sres) & mask;
        exp_c = si ? (ua >= ub + longint'(ci)) : (((ua + ub + longint'(ci)) >> w) != 0);
        run_op(ai, bi, ci, si, $urandom_range(0, 2), s, c, o, lat);
        check($sformatf("sw%0d_%0d_sum", g, n), s, exp_s);
        check($sformatf("sw%0d_%0d_cout", g, n), c, exp_c);
        check($sformatf("sw%0d_%0d_ovf", g, n), o, exp_o);
        check($sformatf("sw%0d_%0d_lat", g, n), lat, nc + 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
